// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory port and holds
// the IF/ID pipeline register. Branch redirects flush IF/ID; freeze stalls it.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    typedef enum logic [1:0] {StReq = 2'd0, StHold = 2'd1, StDrain = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_inc;
    logic        load_bubble;

    assign pc_inc = pc_q + PC_STEP;

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            StReq:   imem_req = 1'b1;
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
            end
            default: imem_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        valid_d      = valid_q;
        load_bubble  = 1'b0;

        case (state_q)
            StReq: begin
                if (branch_taken) begin
                    pc_d        = branch_addr;
                    load_bubble = 1'b1;
                    // Without an ack the request is still in flight and must be drained.
                    if (!imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = StDrain;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (!freeze) begin
                        instr_d = imem_rdata;
                        ifpc_d  = pc_inc;
                        valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_inc;
                        state_d     = StHold;
                    end
                end else if (!freeze) begin
                    load_bubble = 1'b1;
                end
            end
            StHold: begin
                if (branch_taken) begin
                    pc_d        = branch_addr;
                    load_bubble = 1'b1;
                    state_d     = StReq;
                end else if (!freeze) begin
                    instr_d = buf_instr_q;
                    ifpc_d  = buf_pc_q;
                    valid_d = 1'b1;
                    state_d = StReq;
                end
            end
            StDrain: begin
                load_bubble = 1'b1;
                if (branch_taken) pc_d = branch_addr;
                if (imem_ack) state_d = StReq;
            end
            default: state_d = StReq;
        endcase

        if (load_bubble) begin
            instr_d = NOP_INSTR;
            ifpc_d  = 32'h0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            buf_instr_q  <= 32'h0;
            buf_pc_q     <= 32'h0;
            instr_q      <= NOP_INSTR;
            ifpc_q       <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
            valid_q      <= valid_d;
        end
    end

    assign if_instruction = instr_q;
    assign if_pc          = ifpc_q;
    assign if_valid       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle vector table plus an in-order scoreboard of
// fetched instructions that decode is expected to consume.
module tb_if_stage;

    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_valid;

    int wait_cfg = 0;
    int cnt = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int cur_row = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid)
    );

    // Memory model: acks after wait_cfg wait cycles, shares the synchronous reset.
    assign imem_ack   = imem_req && (cnt >= wait_cfg);
    assign imem_rdata = imem_addr ^ XMASK;

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    typedef struct {
        logic        rst;
        int          wt;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        push;
        logic [31:0] paddr;
        logic        chk;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    task automatic row(input logic rst, input int wt, input logic frz, input logic br,
                       input logic [31:0] baddr, input logic push, input logic [31:0] paddr,
                       input logic chk, input logic req, input logic [31:0] addr,
                       input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.wt = wt; v.frz = frz; v.br = br; v.baddr = baddr;
        v.push = push; v.paddr = paddr; v.chk = chk;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        sb_t  e;

        // Zero-wait streaming after reset
        row(1, 0, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h0,   1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h4,   1, 1, 32'h4,  1, 32'h4);
        row(0, 0, 0, 0, 0, 1, 32'h8,   1, 1, 32'h8,  1, 32'h8);
        row(0, 0, 0, 0, 0, 1, 32'hC,   1, 1, 32'hC,  1, 32'hC);
        row(0, 0, 0, 0, 0, 0, 0,       1, 1, 32'h10, 1, 32'h10);
        // Two wait cycles per access
        row(1, 2, 0, 0, 0, 0, 0,       0, 1, 32'h0,  0, 32'h0);
        row(1, 2, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 2, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 2, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 2, 0, 0, 0, 1, 32'h0,   1, 1, 32'h0,  0, 32'h0);
        row(0, 2, 0, 0, 0, 0, 0,       1, 1, 32'h4,  1, 32'h4);
        row(0, 2, 0, 0, 0, 0, 0,       1, 1, 32'h4,  0, 32'h0);
        row(0, 2, 0, 0, 0, 1, 32'h4,   1, 1, 32'h4,  0, 32'h0);
        row(0, 2, 0, 0, 0, 0, 0,       1, 1, 32'h8,  1, 32'h8);
        row(0, 2, 0, 0, 0, 0, 0,       1, 1, 32'h8,  0, 32'h0);
        // Freeze for three cycles while 0x8 is acked
        row(1, 0, 0, 0, 0, 0, 0,       0, 1, 32'h0,  0, 32'h0);
        row(1, 0, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h0,   1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h4,   1, 1, 32'h4,  1, 32'h4);
        row(0, 0, 1, 0, 0, 1, 32'h8,   1, 1, 32'h8,  1, 32'h8);
        row(0, 0, 1, 0, 0, 0, 0,       1, 0, 32'hC,  1, 32'h8);
        row(0, 0, 1, 0, 0, 0, 0,       1, 0, 32'hC,  1, 32'h8);
        row(0, 0, 0, 0, 0, 0, 0,       1, 0, 32'hC,  1, 32'h8);
        row(0, 0, 0, 0, 0, 1, 32'hC,   1, 1, 32'hC,  1, 32'hC);
        row(0, 0, 0, 0, 0, 0, 0,       1, 1, 32'h10, 1, 32'h10);
        // Branch during a three-cycle wait at 0x10
        row(1, 0, 0, 0, 0, 0, 0,       0, 1, 32'h0,  0, 32'h0);
        row(1, 0, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h0,   1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h4,   1, 1, 32'h4,  1, 32'h4);
        row(0, 0, 0, 0, 0, 1, 32'h8,   1, 1, 32'h8,  1, 32'h8);
        row(0, 0, 0, 0, 0, 1, 32'hC,   1, 1, 32'hC,  1, 32'hC);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h10, 1, 32'h10);
        row(0, 3, 0, 1, 32'h100, 0, 0, 1, 1, 32'h10, 0, 32'h0);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h10, 0, 32'h0);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h10, 0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h100, 1, 1, 32'h100, 0, 32'h0);
        row(0, 0, 0, 0, 0, 0, 0,       1, 1, 32'h104, 1, 32'h104);
        // Branch together with freeze while holding a buffered instruction
        row(1, 0, 0, 0, 0, 0, 0,       0, 1, 32'h0,  0, 32'h0);
        row(1, 0, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 1, 0, 0, 0, 0,       1, 1, 32'h4,  1, 32'h4);
        row(0, 0, 1, 1, 32'h200, 0, 0, 1, 0, 32'h8,  1, 32'h4);
        row(0, 0, 0, 0, 0, 1, 32'h200, 1, 1, 32'h200, 0, 32'h0);
        row(0, 0, 0, 0, 0, 0, 0,       1, 1, 32'h204, 1, 32'h204);
        // Reset in the middle of a wait at 0x20
        row(1, 0, 0, 0, 0, 0, 0,       0, 1, 32'h0,  0, 32'h0);
        row(1, 0, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        for (int a = 0; a < 32; a += 4) begin
            row(0, 0, 0, 0, 0, 1, a, 1, 1, a, (a != 0), a);
        end
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h20, 1, 32'h20);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h20, 0, 32'h0);
        row(1, 3, 0, 0, 0, 0, 0,       1, 1, 32'h20, 0, 32'h0);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 3, 0, 0, 0, 1, 32'h0,   1, 1, 32'h0,  0, 32'h0);
        row(0, 3, 0, 0, 0, 0, 0,       1, 1, 32'h4,  1, 32'h4);
        // Branch with a same-cycle ack, then PC wrap past 0xFFFF_FFFC
        row(1, 0, 0, 0, 0, 0, 0,       0, 1, 32'h0,  0, 32'h0);
        row(1, 0, 0, 0, 0, 0, 0,       1, 1, 32'h0,  0, 32'h0);
        row(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 1, 32'h0, 0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
        row(0, 0, 0, 0, 0, 1, 32'h0,   1, 1, 32'h0,  1, 32'h0);
        row(0, 0, 0, 0, 0, 0, 0,       1, 1, 32'h4,  1, 32'h4);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            cur_row = i;
            @(posedge clk);
            #1;
            reset        = v.rst;
            wait_cfg     = v.wt;
            freeze       = v.frz;
            branch_taken = v.br;
            branch_addr  = v.baddr;
            if (v.push) begin
                e.instr = v.paddr ^ XMASK;
                e.pc    = v.paddr + 32'd4;
                sb_q.push_back(e);
            end
            @(negedge clk);
            if (v.chk) begin
                cmp("imem_req", {31'h0, imem_req}, {31'h0, v.req});
                cmp("imem_addr", imem_addr, v.addr);
                cmp("if_valid", {31'h0, if_valid}, {31'h0, v.vld});
                cmp("if_pc", if_pc, v.pc);
                if (!v.vld) cmp("bubble_instr", if_instruction, 32'h0);
            end
            // Decode consumes the IF/ID contents on any unfrozen cycle.
            if (!reset && if_valid && !freeze) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected row %0d: got pc %h expected no instruction",
                             i, if_pc);
                end else begin
                    e = sb_q.pop_front();
                    cmp("sb_instr", if_instruction, e.instr);
                    cmp("sb_pc", if_pc, e.pc);
                end
            end
        end

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
